// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle execute-stage ALU.
// Op codes keep the legacy single-cycle 3-bit encoding.
package alu_pkg;

  localparam logic [2:0] OP_PASSB = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_DIV   = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_muldiv(
    input logic [2:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the issue logic and alu_mc.
// master = producer/consumer side, slave = the ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluop;
  logic             alusrc;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] immd;
  logic [WIDTH-1:0] reg_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid,
    output aluop,
    output alusrc,
    output input1,
    output immd,
    output reg_out,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  zero,
    input  carry,
    input  ovf,
    input  div0
  );

  modport slave (
    input  in_valid,
    input  aluop,
    input  alusrc,
    input  input1,
    input  immd,
    input  reg_out,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output zero,
    output carry,
    output ovf,
    output div0
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider.
// One bit per cycle for WIDTH cycles; done pulses one cycle after the last.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic             isdiv;
  logic             bzero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;

  // x: multiplicand (mul) or dividend/quotient shifter (div)
  assign trial = {rem, x[WIDTH-1]} - {1'b0, y};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      isdiv <= 1'b0;
      bzero <= 1'b0;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        isdiv <= (op == OP_DIV);
        bzero <= (b == '0);
        acc   <= '0;
        x     <= a;
        y     <= b;
        rem   <= '0;
      end else if (busy) begin
        if (isdiv) begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            x   <= {x[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], x[WIDTH-1]};
            x   <= {x[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (y[0]) acc <= acc + x;
          x <= {x[WIDTH-2:0], 1'b0};
          y <= {1'b0, y[WIDTH-1:1]};
        end
        if (cnt == LAST) begin
          busy <= 1'b0;
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign res  = !isdiv ? acc : (bzero ? '1 : x);
  assign div0 = isdiv && bzero;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides.
// Single-cycle ops finish on the accept edge; MUL/DIV go through the core.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MULDIV_EN = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam bit MD = (MULDIV_EN != 0);

  logic [1:0]       state;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             div0_q;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] r1;
  logic             c1;
  logic             v1;
  logic             accept;
  logic             go_md;

  logic             md_done;
  logic [WIDTH-1:0] md_res;
  logic             md_div0;

  assign a      = bus.input1;
  assign b      = bus.alusrc ? bus.immd : bus.reg_out;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};
  assign accept = bus.in_valid && (state == ST_IDLE);
  assign go_md  = MD && is_muldiv(bus.aluop);

  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    unique case (bus.aluop)
      OP_PASSB: r1 = b;
      OP_AND:   r1 = a & b;
      OP_OR:    r1 = a | b;
      OP_XOR:   r1 = a ^ b;
      OP_ADD: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (a[WIDTH-1] == b[WIDTH-1]) &&
             (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = dif[WIDTH-1:0];
        c1 = dif[WIDTH];
        v1 = (a[WIDTH-1] != b[WIDTH-1]) &&
             (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL, OP_DIV: r1 = '0;
    endcase
  end

  generate
    if (MD) begin : g_md
      alu_iter_muldiv #(
        .WIDTH (WIDTH)
      ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && go_md),
        .op    (bus.aluop),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .res   (md_res),
        .div0  (md_div0)
      );
    end else begin : g_nomd
      assign md_done = 1'b0;
      assign md_res  = '0;
      assign md_div0 = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (go_md) begin
              state <= ST_BUSY;
            end else begin
              state   <= ST_DONE;
              res_q   <= r1;
              zero_q  <= (r1 == '0);
              carry_q <= c1;
              ovf_q   <= v1;
              div0_q  <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state   <= ST_DONE;
            res_q   <= md_res;
            zero_q  <= (md_res == '0);
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            div0_q  <= md_div0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=16, MULDIV_EN=1).
// Each task drives one scenario and checks against hand-computed values.
module tb_alu_mc;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_mc_if #(.WIDTH(16)) bus ();

  alu_mc #(
    .WIDTH     (16),
    .MULDIV_EN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(
    input logic [2:0]  op,
    input logic        src,
    input logic [15:0] a,
    input logic [15:0] imm,
    input logic [15:0] rg
  );
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.aluop    = op;
    bus.alusrc   = src;
    bus.input1   = a;
    bus.immd     = imm;
    bus.reg_out  = rg;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.input1   = 16'h1234;
    bus.immd     = 16'h5678;
    bus.reg_out  = 16'h9abc;
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out !== 16'h0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0000", bus.out);
    end
    checks++;
    if ({bus.zero, bus.carry, bus.ovf, bus.div0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.zero, bus.carry, bus.ovf, bus.div0});
    end
  endtask

  task automatic test_add();
    issue(3'd4, 1'b0, 16'hFFFF, 16'h0, 16'h0001);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_valid got=%b exp=1", bus.out_valid);
    end
    checks++;
    if (bus.out !== 16'h0) begin
      errors++;
      $display("FAIL add_out got=%h exp=0000", bus.out);
    end
    checks++;
    if ({bus.zero, bus.carry, bus.ovf, bus.div0} !== 4'b1100) begin
      errors++;
      $display("FAIL add_flags got=%b exp=1100",
               {bus.zero, bus.carry, bus.ovf, bus.div0});
    end
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_release rdy=%b vld=%b exp=1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sub();
    issue(3'd5, 1'b1, 16'h8000, 16'h0001, 16'h7777);
    checks++;
    if (bus.out !== 16'h7FFF) begin
      errors++;
      $display("FAIL sub_out got=%h exp=7fff", bus.out);
    end
    checks++;
    if ({bus.zero, bus.carry, bus.ovf} !== 3'b001) begin
      errors++;
      $display("FAIL sub_flags got=%b exp=001",
               {bus.zero, bus.carry, bus.ovf});
    end
    release_out();
    issue(3'd5, 1'b0, 16'h0003, 16'h0, 16'h0005);
    checks++;
    if (bus.out !== 16'hFFFE || bus.carry !== 1'b1 ||
        bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow got=%h c=%b v=%b exp=fffe 1 0",
               bus.out, bus.carry, bus.ovf);
    end
    release_out();
  endtask

  task automatic test_logic();
    logic [2:0]  ops [4];
    logic [15:0] exp [4];
    ops = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp = '{16'h0FF0, 16'h00F0, 16'hFFF0, 16'hFF00};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 1'b1, 16'hF0F0, 16'h0FF0, 16'hAAAA);
      checks++;
      if (bus.out !== exp[i] || bus.carry !== 1'b0 ||
          bus.zero !== 1'b0) begin
        errors++;
        $display("FAIL logic_op%0d got=%h c=%b z=%b exp=%h 0 0",
                 ops[i], bus.out, bus.carry, bus.zero, exp[i]);
      end
      release_out();
    end
  endtask

  task automatic test_mul();
    int n;
    int busy_rdy;
    issue(3'd6, 1'b0, 16'd300, 16'h0, 16'd300);
    n = 0;
    busy_rdy = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) busy_rdy++;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL mul_latency got=%0d exp=17", n);
    end
    checks++;
    if (busy_rdy !== 0) begin
      errors++;
      $display("FAIL mul_in_ready got=%0d high cycles exp=0",
               busy_rdy);
    end
    checks++;
    if (bus.out !== 16'h5F90 || bus.carry !== 1'b0 ||
        bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_out got=%h c=%b z=%b exp=5f90 0 0",
               bus.out, bus.carry, bus.zero);
    end
    release_out();
  endtask

  task automatic test_div();
    int n;
    int unstable;
    issue(3'd7, 1'b1, 16'd100, 16'd7, 16'h0);
    wait_valid(n);
    checks++;
    if (n !== 17 || bus.out !== 16'd14 || bus.div0 !== 1'b0) begin
      errors++;
      $display("FAIL div_100_7 n=%0d got=%h d0=%b exp=17 000e 0",
               n, bus.out, bus.div0);
    end
    release_out();
    issue(3'd7, 1'b0, 16'd5, 16'h3, 16'h0);
    wait_valid(n);
    checks++;
    if (n !== 17 || bus.out !== 16'hFFFF || bus.div0 !== 1'b1 ||
        bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL div_by0 n=%0d got=%h d0=%b z=%b exp=17 ffff 1 0",
               n, bus.out, bus.div0, bus.zero);
    end
    unstable = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out !== 16'hFFFF ||
          bus.div0 !== 1'b1)
        unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL div_hold got=%0d bad cycles exp=0", unstable);
    end
    release_out();
  endtask

  task automatic test_reset_mid_div();
    int seen;
    issue(3'd7, 1'b1, 16'd100, 16'd7, 16'h0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_div valid=%0d rdy=%b exp=0 1",
               seen, bus.in_ready);
    end
    issue(3'd1, 1'b0, 16'hF0F0, 16'h0, 16'h0FF0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 16'h00F0) begin
      errors++;
      $display("FAIL after_abort_and vld=%b got=%h exp=1 00f0",
               bus.out_valid, bus.out);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    issue(3'd4, 1'b1, 16'h7FFF, 16'h0001, 16'h0);
    checks++;
    if (bus.out !== 16'h8000 || bus.ovf !== 1'b1 ||
        bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL b2b_add got=%h v=%b c=%b exp=8000 1 0",
               bus.out, bus.ovf, bus.carry);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.aluop     = 3'd0;
    bus.alusrc    = 1'b1;
    bus.immd      = 16'h0000;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release vld=%b rdy=%b exp=0 1",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out !== 16'h0 || bus.zero !== 1'b1 ||
        bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pass got=%h z=%b v=%b exp=0000 1 0",
               bus.out, bus.zero, bus.ovf);
    end
    release_out();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluop     = 3'd0;
    bus.alusrc    = 1'b0;
    bus.input1    = 16'h0;
    bus.immd      = 16'h0;
    bus.reg_out   = 16'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_div();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
